// File: rtl/semaforo_lamp_bank.sv
// semaforo_lamp_bank: colour state and one-hot lamp drivers for the 9 signal
// heads of the intersection (6 vehicle, 3 pedestrian).
// Heads advance on one-cycle change pulses and load from set_level on set_load.
// With enable_general=0 all vehicle heads flash yellow and pedestrian heads go dark.
// Optional conflict monitor: define SEMAFORO_CONFLICT_MON_EN to build it;
// otherwise fault is tied low.
module semaforo_lamp_bank #(
  parameter int unsigned BLINK_DIV = 5000
) (
  input  logic        CLK,
  input  logic        reset_general_n,
  input  logic        enable_general,
  input  logic [8:0]  change,
  input  logic [8:0]  set_level,
  input  logic        set_load,
  output logic [17:0] veh_lamp,
  output logic [5:0]  ped_lamp,
  output logic        red_check_NN,
  output logic        fault
);

  typedef enum logic [1:0] {
    VEH_GREEN  = 2'd0,
    VEH_YELLOW = 2'd1,
    VEH_RED    = 2'd2
  } veh_state_t;

  typedef enum logic {
    PED_GREEN = 1'b0,
    PED_RED   = 1'b1
  } ped_state_t;

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  veh_state_t       veh_st_r [6];
  veh_state_t       veh_st_s [6];
  ped_state_t       ped_st_r [3];
  ped_state_t       ped_st_s [3];
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             blink_phase_r;
  logic             blink_phase_s;
  logic             fault_r;
  logic             fault_s;
  logic             hold_s;
  logic [17:0]      veh_lamp_s;
  logic [5:0]       ped_lamp_s;
  logic             red_check_s;

  function automatic veh_state_t veh_advance(input veh_state_t s);
    case (s)
      VEH_GREEN:  return VEH_YELLOW;
      VEH_YELLOW: return VEH_RED;
      VEH_RED:    return VEH_GREEN;
      default:    return VEH_RED;
    endcase
  endfunction

  function automatic logic [2:0] veh_enc(input veh_state_t s);
    case (s)
      VEH_GREEN:  return 3'b001;
      VEH_YELLOW: return 3'b010;
      VEH_RED:    return 3'b100;
      default:    return 3'b100;
    endcase
  endfunction

  function automatic logic [1:0] ped_enc(input ped_state_t s);
    case (s)
      PED_GREEN: return 2'b01;
      PED_RED:   return 2'b10;
      default:   return 2'b10;
    endcase
  endfunction

`ifdef SEMAFORO_CONFLICT_MON_EN
  logic conflict_s;

  // Conflict check on the registered head states; fault latches until reset.
  always_comb begin
    conflict_s = 1'b0;
    if (veh_st_r[2] == VEH_GREEN) begin
      conflict_s = (veh_st_r[0] == VEH_GREEN) || (veh_st_r[1] == VEH_GREEN) ||
                   (ped_st_r[0] == PED_GREEN) || (ped_st_r[1] == PED_GREEN) ||
                   (ped_st_r[2] == PED_GREEN);
    end else begin
      conflict_s = 1'b0;
    end
    hold_s  = fault_r;
    fault_s = fault_r | conflict_s;
  end
`else
  // No monitor: heads are never held and fault stays low.
  always_comb begin
    hold_s  = 1'b0;
    fault_s = 1'b0;
  end
`endif

  // Blink divider: count 0..BLINK_DIV-1, toggle phase on wrap.
  always_comb begin
    cnt_s         = cnt_r;
    blink_phase_s = blink_phase_r;
    if (cnt_r == CNT_LAST) begin
      cnt_s         = '0;
      blink_phase_s = ~blink_phase_r;
    end else begin
      cnt_s         = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      blink_phase_s = blink_phase_r;
    end
  end

  // Head next state: frozen in standby/fault, load beats change.
  always_comb begin
    veh_st_s = veh_st_r;
    ped_st_s = ped_st_r;
    if (!enable_general || hold_s) begin
      veh_st_s = veh_st_r;
      ped_st_s = ped_st_r;
    end else if (set_load) begin
      for (int i = 0; i < 6; i++) begin
        veh_st_s[i] = set_level[i] ? VEH_GREEN : VEH_RED;
      end
      for (int j = 0; j < 3; j++) begin
        ped_st_s[j] = set_level[6+j] ? PED_GREEN : PED_RED;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (change[i]) begin
          veh_st_s[i] = veh_advance(veh_st_r[i]);
        end else begin
          veh_st_s[i] = veh_st_r[i];
        end
      end
      for (int j = 0; j < 3; j++) begin
        if (change[6+j]) begin
          ped_st_s[j] = (ped_st_r[j] == PED_GREEN) ? PED_RED : PED_GREEN;
        end else begin
          ped_st_s[j] = ped_st_r[j];
        end
      end
    end
  end

  // Lamp pattern from next state so a pulse at edge k shows right after edge k.
  always_comb begin
    veh_lamp_s  = 18'b0;
    ped_lamp_s  = 6'b0;
    red_check_s = 1'b0;
    if (fault_s) begin
      for (int i = 0; i < 6; i++) begin
        veh_lamp_s[3*i +: 3] = {1'b0, blink_phase_s, 1'b0};
      end
      ped_lamp_s  = 6'b10_10_10;
      red_check_s = 1'b0;
    end else if (!enable_general) begin
      for (int i = 0; i < 6; i++) begin
        veh_lamp_s[3*i +: 3] = {1'b0, blink_phase_s, 1'b0};
      end
      ped_lamp_s  = 6'b00_00_00;
      red_check_s = 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        veh_lamp_s[3*i +: 3] = veh_enc(veh_st_s[i]);
      end
      for (int j = 0; j < 3; j++) begin
        ped_lamp_s[2*j +: 2] = ped_enc(ped_st_s[j]);
      end
      red_check_s = (veh_st_s[0] == VEH_RED);
    end
  end

  // State, blink and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset_general_n) begin
      for (int i = 0; i < 6; i++) begin
        veh_st_r[i] <= VEH_RED;
      end
      for (int j = 0; j < 3; j++) begin
        ped_st_r[j] <= PED_RED;
      end
      cnt_r         <= '0;
      blink_phase_r <= 1'b1;
      fault_r       <= 1'b0;
      veh_lamp      <= 18'b100_100_100_100_100_100;
      ped_lamp      <= 6'b10_10_10;
      red_check_NN  <= 1'b1;
    end else begin
      veh_st_r      <= veh_st_s;
      ped_st_r      <= ped_st_s;
      cnt_r         <= cnt_s;
      blink_phase_r <= blink_phase_s;
      fault_r       <= fault_s;
      veh_lamp      <= veh_lamp_s;
      ped_lamp      <= ped_lamp_s;
      red_check_NN  <= red_check_s;
    end
  end

  assign fault = fault_r;

endmodule

// File: doc/semaforo_lamp_bank.md
Name: semaforo_lamp_bank

Overview:
- Downstream of the intersection sequencing FSM.
- Holds the actual colour state of all 9 signal heads (6 vehicle, 3 pedestrian). Advances each head on the FSM's one-cycle change pulses and loads initial colours from the FSM's set levels.
- Drives one-hot lamp outputs and returns the NN red-check feedback to the FSM.
- Provides flashing-yellow standby and an optional conflict monitor.

Parameters:
- BLINK_DIV, 5000, CLK cycles per blink half-period (0.5 s at 10 kHz).

Ports:
- CLK  in  1  10 kHz system clock.
- reset_general_n  in  1  synchronous active-low reset.
- enable_general  in  1  1=normal operation, 0=standby (flashing yellow).
- change  in  9  one-cycle advance pulses. Bit map: [0]NN [1]NS [2]TH [3]Giro_NN_izq [4]Giro_NN_der [5]Giro_TH_izq [6]peaton_N [7]peaton_TH1 [8]peaton_TH2.
- set_level  in  9  initial colour per head, same bit map; 1=GREEN, 0=RED.
- set_load  in  1  one-cycle strobe; loads set_level into all heads.
- veh_lamp  out  18  3 bits per vehicle head i at [3i+2:3i] = {R,Y,G}.
- ped_lamp  out  6  2 bits per pedestrian head j at [2j+1:2j] = {R,G}.
- red_check_NN  out  1  1 when NN head state is RED (feeds the FSM red-check input).
- fault  out  1  conflict latched; 0 when SEMAFORO_CONFLICT_MON_EN is undefined.

Behaviour:
- Clock, reset and registers:
  - Single clock, CLK; all state updates on posedge CLK.
  - Reset is synchronous and active-low: reset_general_n=0 sampled at posedge resets.
  - All outputs registered.
- Reset values:
  - All vehicle heads RED (veh_lamp = 18'b100_100_100_100_100_100).
  - All pedestrian heads RED (ped_lamp = 6'b10_10_10).
  - red_check_NN=1, fault=0, blink counter=0, blink_phase=1.
- Vehicle head state (2-bit):
  - Encodings: GREEN, YELLOW, RED.
  - On a change pulse: GREEN->YELLOW->RED->GREEN.
- Pedestrian head state (1-bit):
  - Encodings: GREEN, RED.
  - On a change pulse: toggles.
- Priority per cycle, highest first:
  - reset
  - fault (only if SEMAFORO_CONFLICT_MON_EN is defined)
  - set_load
  - change
- set_load=1:
  - Each head := set_level[i] ? GREEN : RED.
  - Any change bits in the same cycle are ignored.
- change:
  - Every asserted bit advances its head in the same cycle; multiple simultaneous bits are all applied.
  - A held-high bit advances once per cycle. The FSM guarantees single-cycle pulses; no edge detection is performed.
- Latency:
  - A change or set_load sampled at edge k is reflected on veh_lamp/ped_lamp/red_check_NN after edge k (visible in cycle k+1).
- Blink generator (runs whenever not in reset):
  - Counter counts 0..BLINK_DIV-1 and wraps to 0.
  - blink_phase toggles on wrap.
- enable_general=0 (standby):
  - Head states frozen; change and set_load ignored.
  - veh_lamp: every head shows {0,blink_phase,0}.
  - ped_lamp = 0 (dark).
  - red_check_NN = 0.
- Return from standby:
  - Lamps immediately reflect the frozen states again (next cycle).
- Lamp encoding:
  - Outputs are always one-hot per head, or all-zero (dark/blink-off).
  - Never more than one colour per head.

Optional Feature:
- Macro: SEMAFORO_CONFLICT_MON_EN.
- Defined:
  - Each cycle, the registered head states are checked for conflicts:
    - TH GREEN together with NN or NS GREEN; or
    - Any pedestrian head GREEN together with TH GREEN.
  - On a conflict, fault := 1 on the next edge and stays latched until reset.
  - While fault=1:
    - Every vehicle head shows {0,blink_phase,0}.
    - All pedestrian heads show RED.
    - red_check_NN=0.
    - change and set_load are ignored.
    - The fault display overrides standby.
- Undefined:
  - No monitor logic is present.
  - fault is tied 0.

Test Plan:
- Reset sequence: hold reset_general_n=0 for 2 cycles, then enable_general=1 -> veh_lamp=18'h24924, ped_lamp=6'b101010, red_check_NN=1.
- Load, then advance NN:
  - set_level=9'b1_0101_1001, set_load pulse -> NN GREEN, TH RED, red_check_NN=0 the next cycle.
  - change[0] pulse, then again -> NN YELLOW, then RED; red_check_NN=1 one cycle after the second pulse.
- Load/change collision: set_load and change[0] in the same cycle with set_level[0]=1 -> NN GREEN (load wins), not YELLOW.
- Standby:
  - enable_general=0 for 2*BLINK_DIV cycles -> all vehicle Y bits toggle every 5000 cycles, ped_lamp=0.
  - change pulses during standby leave the states unchanged after re-enable.
- Pedestrian toggle: change[8] pulses x3 from RED -> peaton_TH2 GREEN, RED, GREEN; ped_lamp[5:4] = 01, 10, 01.
- Conflict (macro defined): load NN=GREEN and TH=GREEN -> fault=1 one cycle later, all vehicle heads flash yellow, peds RED. A subsequent set_load has no effect; only reset clears fault.
